// File: rtl/parking_gate_controller_if.sv
// Request/spot-register bundle for the parking gate controller.
// master = request side and spot register model, slave = controller.
interface parking_gate_controller_if;
   logic       car_in;
   logic       car_out;
   logic [1:0] out_spot;
   logic [3:0] E;
   logic [3:0] F;
   logic       En;
   logic       make_entry;
   logic [1:0] sel;
   logic       gate_open;
   logic [1:0] spot_id;
   logic       accept;
   logic       reject;
   logic       lot_full;
   logic [2:0] count;

   modport master (
      output car_in, car_out, out_spot, E, F,
      input  En, make_entry, sel, gate_open, spot_id, accept, reject, lot_full, count
   );

   modport slave (
      input  car_in, car_out, out_spot, E, F,
      output En, make_entry, sel, gate_open, spot_id, accept, reject, lot_full, count
   );
endinterface

// File: rtl/parking_gate_controller.sv
// Entry/exit sequencer for the 4-spot register: accept at n+1, write strobe at n+2, gate n+3..n+2+GATE_CYCLES.
// No backpressure: requests are only sampled in IDLE; requesters hold or re-present them.
module parking_gate_controller #(
   parameter int GATE_CYCLES = 8,
   parameter int NUM_SPOTS   = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   parking_gate_controller_if.slave  bus
);

   localparam int GW = (GATE_CYCLES < 1) ? 1 : $clog2(GATE_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ENTRY_WR = 2'd1,
      EXIT_WR  = 2'd2,
      GATE     = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic            en_q, en_d;
   logic            make_entry_q, make_entry_d;
   logic [1:0]      sel_q, sel_d;
   logic            gate_open_q, gate_open_d;
   logic [1:0]      spot_id_q, spot_id_d;
   logic            accept_q, accept_d;
   logic            reject_q, reject_d;
   logic [2:0]      count_q, count_d;
   logic [GW-1:0]   gate_cnt_q, gate_cnt_d;

   logic            free_any;
   logic [1:0]      free_idx;

   // Lowest-numbered free spot wins: scan from the top so index 0 overrides last.
   always_comb begin
      free_any = |bus.E;
      free_idx = 2'd0;
      for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
         if (bus.E[i]) begin
            free_idx = 2'(i);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      en_d         = 1'b0;
      make_entry_d = 1'b0;
      sel_d        = sel_q;
      gate_open_d  = 1'b0;
      spot_id_d    = spot_id_q;
      accept_d     = 1'b0;
      reject_d     = 1'b0;
      count_d      = count_q;
      gate_cnt_d   = gate_cnt_q;

      case (state_q)
         IDLE: begin
            // Exit has priority; a concurrent entry is simply seen again on the next IDLE.
            if (bus.car_out) begin
               if (bus.F[bus.out_spot]) begin
                  sel_d    = bus.out_spot;
                  accept_d = 1'b1;
                  state_d  = EXIT_WR;
               end else begin
                  reject_d = 1'b1;
               end
            end else if (bus.car_in) begin
               if (free_any) begin
                  sel_d     = free_idx;
                  spot_id_d = free_idx;
                  accept_d  = 1'b1;
                  state_d   = ENTRY_WR;
               end else begin
                  reject_d = 1'b1;
               end
            end
         end

         ENTRY_WR: begin
            en_d         = 1'b1;
            make_entry_d = 1'b1;
            if (count_q < 3'(NUM_SPOTS)) begin
               count_d = count_q + 3'd1;
            end
            gate_cnt_d = GW'(GATE_CYCLES);
            state_d    = GATE;
         end

         EXIT_WR: begin
            en_d = 1'b1;
            if (count_q != 3'd0) begin
               count_d = count_q - 3'd1;
            end
            gate_cnt_d = GW'(GATE_CYCLES);
            state_d    = GATE;
         end

         GATE: begin
            if (gate_cnt_q != '0) begin
               gate_open_d = 1'b1;
               gate_cnt_d  = gate_cnt_q - GW'(1);
            end else begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= IDLE;
         en_q         <= 1'b0;
         make_entry_q <= 1'b0;
         sel_q        <= 2'd0;
         gate_open_q  <= 1'b0;
         spot_id_q    <= 2'd0;
         accept_q     <= 1'b0;
         reject_q     <= 1'b0;
         count_q      <= 3'd0;
         gate_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         en_q         <= en_d;
         make_entry_q <= make_entry_d;
         sel_q        <= sel_d;
         gate_open_q  <= gate_open_d;
         spot_id_q    <= spot_id_d;
         accept_q     <= accept_d;
         reject_q     <= reject_d;
         count_q      <= count_d;
         gate_cnt_q   <= gate_cnt_d;
      end
   end

   assign bus.En         = en_q;
   assign bus.make_entry = make_entry_q;
   assign bus.sel        = sel_q;
   assign bus.gate_open  = gate_open_q;
   assign bus.spot_id    = spot_id_q;
   assign bus.accept     = accept_q;
   assign bus.reject     = reject_q;
   assign bus.count      = count_q;
   assign bus.lot_full   = (count_q == 3'(NUM_SPOTS));

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller with a behavioural 4-spot register.
// Expected writes are queued at request time and popped when En appears.
module tb_parking_gate_controller;

   logic CLK;
   logic RST;

   parking_gate_controller_if bus ();

   parking_gate_controller #(.GATE_CYCLES(8), .NUM_SPOTS(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Spot register model: loadable for directed setups, otherwise follows En writes.
   logic [3:0] f_reg = 4'b0000;
   logic       ld = 1'b0;
   logic [3:0] ld_val = 4'b0000;
   always @(posedge CLK) begin
      if (ld)
         f_reg <= ld_val;
      else if (bus.En)
         f_reg[bus.sel] <= bus.make_entry;
   end
   assign bus.F = f_reg;
   assign bus.E = ~f_reg;

   int en_cnt = 0;
   always @(negedge CLK) begin
      if (bus.En === 1'b1)
         en_cnt <= en_cnt + 1;
   end

   typedef struct {
      logic       mk;
      logic [1:0] sel;
   } wr_t;
   wr_t sb[$];

   int total  = 0;
   int passed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic load_f(input logic [3:0] v);
      @(posedge CLK); #1;
      ld = 1'b1;
      ld_val = v;
      @(posedge CLK); #1;
      ld = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
   endtask

   // Present a request for one sampling edge (car_in optionally held), then check accept/reject.
   task automatic request(input string tag, input logic ci, input logic co,
                          input logic [1:0] os, input logic exp_acc, input bit hold_in);
      @(posedge CLK); #1;
      bus.car_in   = ci;
      bus.car_out  = co;
      bus.out_spot = os;
      @(posedge CLK); #1;
      bus.car_out = 1'b0;
      if (!hold_in) bus.car_in = 1'b0;
      @(negedge CLK);
      check({tag, "_accept"}, 32'(bus.accept), 32'(exp_acc));
      check({tag, "_reject"}, 32'(bus.reject), 32'(!exp_acc));
   endtask

   task automatic wait_write(input string tag);
      wr_t e;
      bit  seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge CLK);
         if (bus.En === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         total++;
         $error("FAIL %s_timeout: observed no En within 20 cycles, expected a write", tag);
      end else if (sb.size() == 0) begin
         total++;
         $error("FAIL %s_unexpected: observed En with empty scoreboard, expected none", tag);
      end else begin
         e = sb.pop_front();
         check({tag, "_sel"}, 32'(bus.sel), 32'(e.sel));
         check({tag, "_mk"},  32'(bus.make_entry), 32'(e.mk));
      end
   endtask

   task automatic measure_gate(input string tag);
      int hi;
      bit done;
      hi = 0;
      done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge CLK);
         if (k == 0) check({tag, "_en_one_cycle"}, 32'(bus.En), 32'd0);
         if (bus.gate_open === 1'b1) hi++;
         else if (hi > 0) done = 1'b1;
      end
      check({tag, "_gate_cycles"}, 32'(hi), 32'd8);
   endtask

   task automatic entry(input string tag, input logic [1:0] exp_sel);
      request(tag, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
      sb.push_back('{mk: 1'b1, sel: exp_sel});
      wait_write(tag);
      measure_gate(tag);
      check({tag, "_spot_id"}, 32'(bus.spot_id), 32'(exp_sel));
   endtask

   initial begin
      int e0;
      int hi;
      bit seen;
      RST = 1'b1;
      bus.car_in = 1'b0;
      bus.car_out = 1'b0;
      bus.out_spot = 2'd0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      check("rst_en",       32'(bus.En), 32'd0);
      check("rst_gate",     32'(bus.gate_open), 32'd0);
      check("rst_count",    32'(bus.count), 32'd0);
      check("rst_lot_full", 32'(bus.lot_full), 32'd0);
      check("rst_accept",   32'(bus.accept), 32'd0);
      check("rst_spot_id",  32'(bus.spot_id), 32'd0);

      // First entry into an empty lot, with exact latency of the write strobe.
      request("e0", 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
      check("e0_en_not_yet", 32'(bus.En), 32'd0);
      sb.push_back('{mk: 1'b1, sel: 2'd0});
      @(negedge CLK);
      check("e0_en_lat", 32'(bus.En), 32'd1);
      check("e0_sel", 32'(bus.sel), 32'd0);
      check("e0_mk",  32'(bus.make_entry), 32'd1);
      void'(sb.pop_front());
      measure_gate("e0");
      check("e0_count",   32'(bus.count), 32'd1);
      check("e0_spot_id", 32'(bus.spot_id), 32'd0);

      entry("e1", 2'd1);
      entry("e2", 2'd2);
      entry("e3", 2'd3);
      check("full_count",    32'(bus.count), 32'd4);
      check("full_lot_full", 32'(bus.lot_full), 32'd1);

      e0 = en_cnt;
      request("e4_full", 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      repeat (4) @(negedge CLK);
      check("e4_no_en", 32'(en_cnt), 32'(e0));
      check("e4_count", 32'(bus.count), 32'd4);

      // Exit from a full lot, then the freed spot is reused.
      request("x2", 1'b0, 1'b1, 2'd2, 1'b1, 1'b0);
      sb.push_back('{mk: 1'b0, sel: 2'd2});
      wait_write("x2");
      measure_gate("x2");
      check("x2_count",    32'(bus.count), 32'd3);
      check("x2_lot_full", 32'(bus.lot_full), 32'd0);
      entry("e5", 2'd2);
      check("e5_count", 32'(bus.count), 32'd4);

      // Exit of an already-empty spot.
      load_f(4'b1101);
      e0 = en_cnt;
      request("x1_empty", 1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
      repeat (4) @(negedge CLK);
      check("x1_no_en", 32'(en_cnt), 32'(e0));
      check("x1_count", 32'(bus.count), 32'd4);

      // Register disagrees with count: entry proceeds, count saturates at 4.
      entry("e6_sat", 2'd1);
      check("e6_count", 32'(bus.count), 32'd4);

      // Simultaneous entry and exit after reset: exit first (count floors at 0), then held entry.
      do_reset();
      load_f(4'b0001);
      request("sim", 1'b1, 1'b1, 2'd0, 1'b1, 1'b1);
      sb.push_back('{mk: 1'b0, sel: 2'd0});
      sb.push_back('{mk: 1'b1, sel: 2'd0});
      wait_write("sim_x");
      measure_gate("sim_x");
      check("sim_x_count", 32'(bus.count), 32'd0);
      wait_write("sim_e");
      bus.car_in = 1'b0;
      measure_gate("sim_e");
      check("sim_e_count",   32'(bus.count), 32'd1);
      check("sim_e_spot_id", 32'(bus.spot_id), 32'd0);

      // Reset while the gate is open.
      request("rg", 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
      sb.push_back('{mk: 1'b1, sel: 2'd1});
      wait_write("rg");
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge CLK);
         if (bus.gate_open === 1'b1) seen = 1'b1;
      end
      check("rg_gate_seen", 32'(seen), 32'd1);
      do_reset();
      @(negedge CLK);
      check("rg_gate",  32'(bus.gate_open), 32'd0);
      check("rg_count", 32'(bus.count), 32'd0);
      check("rg_en",    32'(bus.En), 32'd0);
      e0 = en_cnt;
      hi = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge CLK);
         if (bus.gate_open === 1'b1) hi++;
      end
      check("rg_no_en",   32'(en_cnt), 32'(e0));
      check("rg_no_gate", 32'(hi), 32'd0);
      check("sb_empty",   32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
